// File: rtl/vdc_video_timing.sv
// Raster sequencer for the HuC6270 VDC: dot-rate divider, ROW/COL position bus and sync/blank strobes.
// Define VDC_TIMING_FIELD_EN to alternate fields, with odd fields carrying one extra line.
module vdc_video_timing #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 341,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 280,
    parameter int H_SYNC_LEN   = 25,
    parameter int V_TOTAL      = 263,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 245,
    parameter int V_SYNC_LEN   = 3
) (
    input  logic       CLK,
    input  logic       RESn,
    input  logic       CE,
    input  logic       EN,
    output logic       PCE,
    output logic [8:0] ROW,
    output logic [8:0] COL,
    output logic       HSYNCn,
    output logic       VSYNCn,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       FRAME_START,
    output logic       FIELD
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [8:0] COL_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] ROW_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] COL_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] ROW_ACT  = 9'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_SYNC_START);
    localparam logic [9:0] HS_END   = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0] VS_FIRST = 10'(V_SYNC_START);
    localparam logic [9:0] VS_END   = 10'(V_SYNC_START + V_SYNC_LEN);

    logic       adv_s;
    logic       pce_s;
    logic       line_end_s;
    logic       frame_end_s;
    logic [3:0] div_r;
    logic [3:0] div_nxt_s;
    logic [8:0] col_r;
    logic [8:0] col_nxt_s;
    logic [8:0] row_r;
    logic [8:0] row_nxt_s;
    logic [8:0] row_last_s;
    logic       field_s;

`ifdef VDC_TIMING_FIELD_EN
    logic field_r;
    logic field_nxt_s;

    // Odd fields run one line longer, so the last row moves with the field bit.
    assign row_last_s = ROW_LAST + {8'd0, field_r};
    assign field_s    = field_r;

    // Field parity flips on every frame wrap.
    always_comb begin
        field_nxt_s = field_r;
        if (frame_end_s) begin
            field_nxt_s = ~field_r;
        end else begin
            field_nxt_s = field_r;
        end
    end

    // Field parity register.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            field_r <= 1'b0;
        end else begin
            field_r <= field_nxt_s;
        end
    end
`else
    assign row_last_s = ROW_LAST;
    assign field_s    = 1'b0;
`endif

    // Divider and raster position next-state; everything holds unless CE and EN are both high.
    always_comb begin
        adv_s       = CE & EN;
        pce_s       = adv_s & (div_r == DIV_LAST);
        line_end_s  = (col_r == COL_LAST);
        frame_end_s = pce_s & line_end_s & (row_r == row_last_s);
        div_nxt_s   = div_r;
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        if (adv_s) begin
            if (div_r == DIV_LAST) begin
                div_nxt_s = 4'd0;
            end else begin
                div_nxt_s = div_r + 4'd1;
            end
        end else begin
            div_nxt_s = div_r;
        end
        if (pce_s) begin
            if (line_end_s) begin
                col_nxt_s = 9'd0;
                if (frame_end_s) begin
                    row_nxt_s = 9'd0;
                end else begin
                    row_nxt_s = row_r + 9'd1;
                end
            end else begin
                col_nxt_s = col_r + 9'd1;
                row_nxt_s = row_r;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
    end

    // Divider and position registers.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            div_r <= 4'd0;
            col_r <= 9'd0;
            row_r <= 9'd0;
        end else begin
            div_r <= div_nxt_s;
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    // Strobes decode straight from the registered position so they track ROW/COL with no lag.
    assign PCE         = pce_s;
    assign ROW         = row_r;
    assign COL         = col_r;
    assign HSYNCn      = ~(({1'b0, col_r} >= HS_FIRST) && ({1'b0, col_r} < HS_END));
    assign VSYNCn      = ~(({1'b0, row_r} >= VS_FIRST) && ({1'b0, row_r} < VS_END));
    assign HBLANK      = (col_r >= COL_ACT);
    assign VBLANK      = (row_r >= ROW_ACT);
    assign FRAME_START = pce_s & (row_r == 9'd0) & (col_r == 9'd0);
    assign FIELD       = field_s;

endmodule
